// File: rtl/smem_rd_arbiter_if.sv
// Request/response bundle between the SMEM pipeline requesters, the read
// arbiter and the host read channel.
//   master : arbiter side (drives req_ready, cor_tx_rd_*, rsp_*)
//   slave  : requesters + host side (drives req_valid/addr, almostfull, rx_rd_*)
interface smem_rd_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 6
);
    localparam int unsigned ADDR_W = 58;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned LEN_W  = 6;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      tx_rd_almostfull;
    logic                      cor_tx_rd_valid;
    logic [ADDR_W-1:0]         cor_tx_rd_addr;
    logic [LEN_W-1:0]          cor_tx_rd_len;
    logic [TAG_W-1:0]          cor_tx_rd_tag;

    logic                      rx_rd_valid;
    logic [TAG_W-1:0]          rx_rd_tag;
    logic [DATA_W-1:0]         rx_rd_data;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        input  req_valid, req_addr, tx_rd_almostfull,
        input  rx_rd_valid, rx_rd_tag, rx_rd_data,
        output req_ready, cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_rd_len, cor_tx_rd_tag,
        output rsp_valid, rsp_data
    );

    modport slave (
        output req_valid, req_addr, tx_rd_almostfull,
        output rx_rd_valid, rx_rd_tag, rx_rd_data,
        input  req_ready, cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_rd_len, cor_tx_rd_tag,
        input  rsp_valid, rsp_data
    );
endinterface

// File: rtl/smem_rd_arbiter.sv
// Shares the core-side memory read port among NUM_REQ SMEM requesters.
// Round-robin grant, lowest-free tag allocation, outstanding-read credit
// limit and host backpressure; responses are routed back by tag and may
// return out of order.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   arb_enable    : issue enable (responses are always accepted)
//   bus           : requester handshake, read issue and response channels
//   outstanding   : reads in flight
//   idle          : nothing in flight and no issue pending
//   err_spurious  : sticky, response arrived on a tag not in use
module smem_rd_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned TAG_W           = 6,
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arb_enable,
    smem_rd_arbiter_if.master     bus,
    output logic [TAG_W:0]        outstanding,
    output logic                  idle,
    output logic                  err_spurious
);
    localparam int unsigned ADDR_W    = 58;
    localparam int unsigned DATA_W    = 512;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W     = TAG_W + 1;
    localparam int unsigned TAG_SPACE = 1 << TAG_W;

    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [TAG_SPACE-1:0] busy_q, busy_d;
    logic [PTR_W-1:0]     owner_q [TAG_SPACE];
    logic [CNT_W-1:0]     outst_q, outst_d;
    logic                 rd_valid_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic [TAG_W-1:0]     rd_tag_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]    rsp_data_q;
    logic                 err_q;
    logic                 idle_q;

    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     cand;
    logic                 alloc_found;
    logic [TAG_W-1:0]     alloc_tag;
    logic                 can_issue;
    logic                 accept;
    logic                 rsp_hit;
    logic [ADDR_W-1:0]    req_addr_arr [NUM_REQ];

    // Unpack the flat address bus into one entry per requester
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign req_addr_arr[i] = bus.req_addr[ADDR_W*i +: ADDR_W];
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(rr_q) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Lowest-index free tag from the pool; tags at or above
    // MAX_OUTSTANDING are never handed out
    always_comb begin
        alloc_found = 1'b0;
        alloc_tag   = '0;
        for (int unsigned t = 0; t < MAX_OUTSTANDING; t++) begin
            if (!alloc_found && !busy_q[TAG_W'(t)]) begin
                alloc_found = 1'b1;
                alloc_tag   = TAG_W'(t);
            end
        end
    end

    // Issue permission depends only on registered state and global inputs
    assign can_issue = arb_enable & ~bus.tx_rd_almostfull
                     & (outst_q < CNT_W'(MAX_OUTSTANDING)) & alloc_found;
    assign accept    = grant_found & can_issue;
    assign rsp_hit   = bus.rx_rd_valid & busy_q[bus.rx_rd_tag];

    assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    // Next-state for pointer, tag pool and credit counter
    always_comb begin
        rr_d    = rr_q;
        busy_d  = busy_q;
        outst_d = outst_q;
        if (rsp_hit) begin
            busy_d[bus.rx_rd_tag] = 1'b0;
        end
        if (accept) begin
            busy_d[alloc_tag] = 1'b1;
            rr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
        case ({accept, rsp_hit})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q        <= '0;
            busy_q      <= '0;
            outst_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_tag_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            idle_q      <= 1'b1;
            for (int unsigned i = 0; i < TAG_SPACE; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            busy_q     <= busy_d;
            outst_q    <= outst_d;
            rd_valid_q <= accept;
            idle_q     <= (outst_d == '0) && !accept;
            if (accept) begin
                owner_q[alloc_tag] <= grant_idx;
                rd_addr_q          <= req_addr_arr[grant_idx];
                rd_tag_q           <= alloc_tag;
            end
            rsp_valid_q <= rsp_hit ? (NUM_REQ'(1) << owner_q[bus.rx_rd_tag]) : '0;
            if (rsp_hit) begin
                rsp_data_q <= bus.rx_rd_data;
            end
            if (bus.rx_rd_valid && !rsp_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.cor_tx_rd_valid = rd_valid_q;
    assign bus.cor_tx_rd_addr  = rd_addr_q;
    assign bus.cor_tx_rd_len   = LEN_W'(1);
    assign bus.cor_tx_rd_tag   = rd_tag_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_data        = rsp_data_q;
    assign outstanding         = outst_q;
    assign idle                = idle_q;
    assign err_spurious        = err_q;
endmodule

// File: tb/tb_smem_rd_arbiter.sv
// Bench for smem_rd_arbiter: a vector table for the directed scenarios,
// hand-written reset/spurious/credit sequences, then random traffic
// checked against a tag-pool reference model.
module tb_smem_rd_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned TW = 6;
    localparam int unsigned MO = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          arb_enable;
    logic [TW:0]   outstanding;
    logic          idle;
    logic          err_spurious;

    int n_checks = 0;
    int n_pass   = 0;

    smem_rd_arbiter_if #(.NUM_REQ(NR), .TAG_W(TW)) bus ();

    smem_rd_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .MAX_OUTSTANDING(MO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .arb_enable   (arb_enable),
        .bus          (bus),
        .outstanding  (outstanding),
        .idle         (idle),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        logic [3:0] valid;
        bit         af;
        bit         rxv;
        logic [5:0] rxtag;
        logic [3:0] ready;
        bit         txv;
        int         areq;
        logic [5:0] tag;
        logic [3:0] rsp;
        int         outst;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [57:0] addr_of(input int i);
        return 58'h100 + 58'(i) * 58'h40;
    endfunction

    function automatic logic [511:0] data_of(input logic [5:0] tag);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = 32'hA500_0000 + 32'(tag) * 32'h101 + 32'(w);
        return d;
    endfunction

    function automatic vec_t mk(input bit en, input logic [3:0] v, input bit af, input bit rxv,
                                input logic [5:0] rt, input logic [3:0] rdy, input bit txv,
                                input int areq, input logic [5:0] tg, input logic [3:0] rsp,
                                input int outst);
        vec_t r;
        r.en = en; r.valid = v; r.af = af; r.rxv = rxv; r.rxtag = rt;
        r.ready = rdy; r.txv = txv; r.areq = areq; r.tag = tg; r.rsp = rsp; r.outst = outst;
        return r;
    endfunction

    task automatic drive(input bit en, input logic [3:0] v, input bit af, input bit rxv,
                         input logic [5:0] rt, input logic [511:0] d);
        arb_enable           = en;
        bus.req_valid        = v;
        bus.tx_rd_almostfull = af;
        bus.rx_rd_valid      = rxv;
        bus.rx_rd_tag        = rt;
        bus.rx_rd_data       = d;
    endtask

    task automatic reset_pulse();
        drive(1'b0, 4'b0, 1'b0, 1'b0, 6'd0, '0);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_txv"},   bus.cor_tx_rd_valid, 0);
        check({pfx, "_addr"},  bus.cor_tx_rd_addr, 0);
        check({pfx, "_tag"},   bus.cor_tx_rd_tag, 0);
        check({pfx, "_rsp"},   bus.rsp_valid, 0);
        check({pfx, "_data"},  bus.rsp_data, 0);
        check({pfx, "_outst"}, outstanding, 0);
        check({pfx, "_err"},   err_spurious, 0);
        check({pfx, "_idle"},  idle, 1);
    endtask

    // Reference model state
    bit         m_busy [64];
    int         m_owner[64];
    int         m_rr, m_cnt;
    bit         m_err;
    bit         e_txv;
    logic [57:0]  e_addr;
    logic [5:0]   e_tag;
    logic [3:0]   e_rsp;
    logic [511:0] e_data;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin m_busy[i] = 1'b0; m_owner[i] = 0; end
        m_rr = 0; m_cnt = 0; m_err = 1'b0;
        e_txv = 1'b0; e_addr = '0; e_tag = '0; e_rsp = '0; e_data = '0;
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) bus.req_addr[i*58 +: 58] = addr_of(i);
        drive(1'b0, 4'b0, 1'b0, 1'b0, 6'd0, '0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_reset_outputs("reset");
        check("reset_len", bus.cor_tx_rd_len, 6'h1);

        // Directed vectors: inputs, same-cycle ready, outputs after the edge
        tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 0, 0, 4'b0000, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 0, 4'b0001, 0));
        tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0001, 1, 0, 0, 4'b0000, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 4'b0010, 1, 1, 1, 4'b0000, 2));
        tbl.push_back(mk(1, 4'b0100, 0, 0, 0, 4'b0100, 1, 2, 2, 4'b0000, 3));
        tbl.push_back(mk(1, 4'b1000, 0, 0, 0, 4'b1000, 1, 3, 3, 4'b0000, 4));
        tbl.push_back(mk(1, 4'b0000, 0, 1, 3, 4'b0000, 0, 3, 3, 4'b1000, 3));
        tbl.push_back(mk(1, 4'b0000, 0, 1, 1, 4'b0000, 0, 3, 3, 4'b0010, 2));
        tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 4'b0000, 0, 3, 3, 4'b0001, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 1, 2, 4'b0000, 0, 3, 3, 4'b0100, 0));
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0001, 1, 0, 0, 4'b0000, 1));
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0010, 1, 1, 1, 4'b0000, 2));
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0100, 1, 2, 2, 4'b0000, 3));
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b1000, 1, 3, 3, 4'b0000, 4));
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0001, 1, 0, 4, 4'b0000, 5));
        tbl.push_back(mk(1, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 4, 4'b0000, 5));
        tbl.push_back(mk(1, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 4, 4'b0000, 5));
        tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 4'b0010, 1, 1, 5, 4'b0000, 6));
        tbl.push_back(mk(1, 4'b1111, 0, 1, 0, 4'b0100, 1, 2, 6, 4'b0001, 6));
        tbl.push_back(mk(1, 4'b1000, 0, 0, 0, 4'b1000, 1, 3, 0, 4'b0000, 7));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 1, 4'b0000, 0, 3, 0, 4'b0010, 6));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t r;
            r = tbl[i];
            drive(r.en, r.valid, r.af, r.rxv, r.rxtag, data_of(r.rxtag));
            #3;
            check($sformatf("row%0d_ready", i), bus.req_ready, r.ready);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_txv", i),   bus.cor_tx_rd_valid, r.txv);
            check($sformatf("row%0d_addr", i),  bus.cor_tx_rd_addr, addr_of(r.areq));
            check($sformatf("row%0d_tag", i),   bus.cor_tx_rd_tag, r.tag);
            check($sformatf("row%0d_rsp", i),   bus.rsp_valid, r.rsp);
            if (r.rsp != 4'b0000)
                check($sformatf("row%0d_data", i), bus.rsp_data, data_of(r.rxtag));
            check($sformatf("row%0d_outst", i), outstanding, 7'(r.outst));
            check($sformatf("row%0d_idle", i),  idle, (r.outst == 0) && !r.txv);
        end

        // Reset in the middle of traffic: reads still in flight are discarded
        drive(1'b0, 4'b0, 1'b0, 1'b0, 6'd0, '0);
        check("pre_reset_outst", outstanding, 7'd6);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Spurious tag while idle
        drive(1'b0, 4'b0, 1'b0, 1'b1, 6'd9, data_of(6'd9));
        @(posedge clk); #1;
        check("spur9_err",   err_spurious, 1);
        check("spur9_rsp",   bus.rsp_valid, 0);
        check("spur9_outst", outstanding, 0);
        check("spur9_idle",  idle, 1);

        // Late response for a read issued before reset
        reset_pulse();
        check("late_err_clear", err_spurious, 0);
        drive(1'b0, 4'b0, 1'b0, 1'b1, 6'd2, data_of(6'd2));
        @(posedge clk); #1;
        check("late_err",   err_spurious, 1);
        check("late_rsp",   bus.rsp_valid, 0);
        check("late_outst", outstanding, 0);

        // Credit limit: 40 request cycles with no responses
        reset_pulse();
        begin
            int issued;
            logic [5:0] last_tag;
            issued = 0;
            last_tag = '0;
            drive(1'b1, 4'b0001, 1'b0, 1'b0, 6'd0, '0);
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (bus.cor_tx_rd_valid) begin issued++; last_tag = bus.cor_tx_rd_tag; end
            end
            check("credit_issued",   32'(issued), 32);
            check("credit_last_tag", last_tag, 6'd31);
            check("credit_outst",    outstanding, 7'd32);
            check("credit_ready",    bus.req_ready, 0);
            drive(1'b1, 4'b0001, 1'b0, 1'b1, 6'd17, data_of(6'd17));
            @(posedge clk); #1;
            check("credit_rsp",      bus.rsp_valid, 4'b0001);
            check("credit_rsp_data", bus.rsp_data, data_of(6'd17));
            drive(1'b1, 4'b0001, 1'b0, 1'b0, 6'd0, '0);
            issued = 0;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                if (bus.cor_tx_rd_valid) begin issued++; last_tag = bus.cor_tx_rd_tag; end
            end
            check("credit_refill_issued", 32'(issued), 1);
            check("credit_refill_tag",    last_tag, 6'd17);
            check("credit_refill_outst",  outstanding, 7'd32);
        end

        // Random traffic against the reference model
        reset_pulse();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit           en, af, rxv, can, acc, hit;
            logic [3:0]   v, exp_ready;
            logic [5:0]   rt;
            logic [511:0] d;
            int           busy_list[$];
            int           g, ft, r;

            en = ($urandom % 10) != 0;
            af = ($urandom % 5) == 0;
            v  = 4'($urandom);
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            for (int t = 0; t < 64; t++) if (m_busy[t]) busy_list.push_back(t);
            r = int'($urandom % 100);
            rxv = 1'b0;
            rt  = 6'($urandom);
            if (busy_list.size() > 0 && r < 40) begin
                rxv = 1'b1;
                rt  = 6'(busy_list[$urandom % busy_list.size()]);
            end else if (r >= 98 && !m_busy[rt]) begin
                rxv = 1'b1;
            end
            drive(en, v, af, rxv, rt, d);

            ft = -1;
            for (int t = 0; t < int'(MO); t++) if (ft < 0 && !m_busy[t]) ft = t;
            can = en && !af && (m_cnt < int'(MO)) && (ft >= 0);
            g = -1;
            for (int k = 0; k < int'(NR); k++) begin
                int j;
                j = (m_rr + k) % int'(NR);
                if (g < 0 && v[j]) g = j;
            end
            acc = can && (g >= 0);
            exp_ready = acc ? 4'(1 << g) : 4'b0000;
            hit = rxv && m_busy[rt];

            #3;
            check($sformatf("rnd%0d_ready", cyc), bus.req_ready, exp_ready);

            if (hit) begin
                e_rsp = 4'(1 << m_owner[rt]);
                e_data = d;
                m_busy[rt] = 1'b0;
                m_cnt--;
            end else begin
                e_rsp = 4'b0000;
            end
            if (rxv && !hit) m_err = 1'b1;
            e_txv = acc;
            if (acc) begin
                m_busy[ft]  = 1'b1;
                m_owner[ft] = g;
                m_cnt++;
                m_rr   = (g + 1) % int'(NR);
                e_addr = addr_of(g);
                e_tag  = 6'(ft);
            end

            @(posedge clk); #1;
            check($sformatf("rnd%0d_txv", cyc),   bus.cor_tx_rd_valid, e_txv);
            check($sformatf("rnd%0d_addr", cyc),  bus.cor_tx_rd_addr, e_addr);
            check($sformatf("rnd%0d_tag", cyc),   bus.cor_tx_rd_tag, e_tag);
            check($sformatf("rnd%0d_rsp", cyc),   bus.rsp_valid, e_rsp);
            check($sformatf("rnd%0d_data", cyc),  bus.rsp_data, e_data);
            check($sformatf("rnd%0d_outst", cyc), outstanding, 7'(m_cnt));
            check($sformatf("rnd%0d_err", cyc),   err_spurious, m_err);
            check($sformatf("rnd%0d_idle", cyc),  idle, (m_cnt == 0) && !e_txv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/smem_rd_arbiter.md
Name: smem_rd_arbiter

Overview:
- Shares the single core-side memory read request port (cor_tx_rd_*) among NUM_REQ SMEM pipeline requesters.
- Round-robin arbitration, tag allocation from a free pool, outstanding-read credit limit, and host backpressure.
- Routes each read response back to its originating requester by tag; responses may return out of order.
- Sits between the SMEM pipeline stages and the host I/O block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 6, tag width; tag is carried in the low bits of read mdata.
- MAX_OUTSTANDING, 32, maximum reads in flight; must be ≤ 2^TAG_W.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- arb_enable  in  1  issue enable, driven from core_start; responses are accepted regardless.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*58  per-requester cache-line address; slice i = [58*i+57:58*i].
- req_ready  out  NUM_REQ  combinational; one-hot or zero.
- tx_rd_almostfull  in  1  host read channel backpressure.
- cor_tx_rd_valid  out  1  registered read issue.
- cor_tx_rd_addr  out  58  issued address.
- cor_tx_rd_len  out  6  always 6'h1.
- cor_tx_rd_tag  out  TAG_W  allocated tag.
- rx_rd_valid  in  1  read response valid.
- rx_rd_tag  in  TAG_W  response tag (mdata[TAG_W-1:0]).
- rx_rd_data  in  512  response data.
- rsp_valid  out  NUM_REQ  one-hot response pulse.
- rsp_data  out  512  response data, shared by all requesters.
- outstanding  out  TAG_W+1  reads in flight.
- idle  out  1  outstanding==0 and no issue pending.
- err_spurious  out  1  sticky; set on a response whose tag is not in use.

Behaviour:
- Reset (async assert, sync deassert use): cor_tx_rd_valid=0, addr=0, tag=0, rsp_valid=0, rsp_data=0, outstanding=0, err_spurious=0, all tags free, RR pointer=0. idle=1.
- can_issue = arb_enable & ~tx_rd_almostfull & (outstanding < MAX_OUTSTANDING) & (any tag free).
- Grant: the first requester with req_valid at or after the RR pointer, wrapping modulo NUM_REQ. req_ready[g]=can_issue; all other ready bits are 0. No combinational path from req_valid to can_issue.
- Accept: req_valid[g] & req_ready[g]. On accept:
  - Allocate the lowest-index free tag.
  - Record owner[tag]=g and mark the tag busy.
  - RR pointer <= g+1 (mod NUM_REQ).
  - Next cycle: cor_tx_rd_valid=1, addr=req_addr slice g, tag=allocated tag, len=1.
  - Issue latency is 1 cycle; at most one issue per cycle.
- With no accept, cor_tx_rd_valid=0 and addr/tag hold their last values.
- Response, 1-cycle latency, for rx_rd_valid with busy[rx_rd_tag]:
  - rsp_valid[owner]=1 and rsp_data=rx_rd_data on the next cycle.
  - The tag is freed at that edge.
  - Requesters cannot stall responses.
- Spurious response (rx_rd_valid with a free tag): no rsp pulse, err_spurious<=1, counters unchanged.
- Counter update: outstanding += accept − valid_response.
  - Simultaneous accept and response leaves it unchanged.
  - A freed tag is allocatable from the following cycle, not the same one.
  - The counter never wraps.
- Almostfull asserted mid-stream: no new accept starts that cycle. A request accepted in the previous cycle is still issued (the host tolerates one cycle of skid).
- arb_enable deasserted: issue stops; in-flight responses still return; idle rises once drained.
- Reset mid-operation: all state is discarded; late responses after reset count as spurious.

Test Plan:
- Single request: req 0 at addr 0x100 with enable → ready[0] same cycle; next cycle valid=1, addr=0x100, tag=0. Response tag 0 → rsp_valid=4'b0001 one cycle later; outstanding returns 1→0.
- Fairness: all 4 requesters valid continuously → grants 0,1,2,3,0,…; tags 0,1,2,3,… issued back-to-back.
- Credit limit: 40 requests, no responses → exactly 32 issued; outstanding=32, ready=0. One response → exactly one more issue, reusing the freed tag.
- Out-of-order routing: tags 0–3 owned by requesters 0–3, responses in order 3,1,0,2 → rsp_valid 1000, 0010, 0001, 0100, with matching data.
- Backpressure: almostfull for 5 cycles with requests pending → no accepts during those cycles; issue resumes the cycle after deassert.
- Spurious tag and reset: response tag 9 while idle → err_spurious=1, no rsp. Reset asserted with 3 reads in flight → all outputs at reset values immediately; outstanding=0.
